// File: rtl/test_serializer_pkg.sv
// Shared definitions for the test_serializer block.
//   - FSM state encodings (IDLE, SHIFT, PAR), held as fixed 2-bit constants
//     so the encoding stays stable across builds.
//   - Default frame width and bit-counter width for the default byte size.
//   - bit_cnt_w(): bit-counter width for an arbitrary byte width.
// Optional feature macro: TEST_SERIALIZER_PARITY_EN (PAR state is only
// reachable when it is defined).
package test_serializer_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] PAR   = 2'd2;

  localparam int DATA_W_DEF = 8;
  localparam int FRAME_W    = 2 * DATA_W_DEF;
  localparam int BIT_CNT_W  = $clog2(FRAME_W);

  // Counter wide enough to index every data bit of a 2*data_w frame.
  function automatic int bit_cnt_w(input int data_w);
    return $clog2(2 * data_w);
  endfunction

endpackage

// File: rtl/test_serializer_fifo.sv
// Synchronous pair-buffer FIFO for test_serializer.
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   wr_en, wr_data    write request; ignored while full
//   full              no space for another entry
//   rd_en, rd_data    read request (ignored while empty); rd_data shows the
//                     head entry combinationally
//   empty, count      occupancy derived from the registered count
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module test_serializer_fifo
  import test_serializer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     full,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  // A pop in the same cycle does not free space for a push: no fall-through.
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/test_serializer.sv
// test_serializer: buffers {in_a, in_b} byte pairs and shifts each pair out
// as a serial frame, MSB first, with bit-level valid/ready backpressure.
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   in_valid, in_ready    pair handshake (in_ready = FIFO not full)
//   in_a, in_b            first / second byte of the pair
//   ser_out, ser_valid    registered serial bit and its valid
//   ser_last              registered flag marking the final bit of a frame
//   ser_ready             sink consumes the presented bit on this edge
//   fifo_count            buffered pairs
//   frame_cnt             frames whose last bit was consumed, wraps at 256
// Optional macro TEST_SERIALIZER_PARITY_EN appends an even-parity bit
// (PAR state) to every frame.
module test_serializer
  import test_serializer_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_a,
  input  logic [DATA_W-1:0]             in_b,
  output logic                          ser_out,
  output logic                          ser_valid,
  output logic                          ser_last,
  input  logic                          ser_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    frame_cnt
);

  localparam int FW = 2 * DATA_W;
  localparam int CW = bit_cnt_w(DATA_W);

  logic [FW-1:0] fifo_rd_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          out_free;
  logic          data_last;
  logic          frame_end;

  logic [1:0]    state;
  logic [FW-1:0] shreg;
  logic [CW-1:0] bit_cnt;
`ifdef TEST_SERIALIZER_PARITY_EN
  logic          par_acc;
`endif

  test_serializer_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (in_valid),
    .wr_data ({in_a, in_b}),
    .full    (fifo_full),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign in_ready = !fifo_full;

  // The output bit register is free when it is empty or being consumed now.
  assign out_free  = !ser_valid || ser_ready;
  assign data_last = (bit_cnt == CW'(FW - 1));
`ifdef TEST_SERIALIZER_PARITY_EN
  assign frame_end = (state == PAR) && out_free;
`else
  assign frame_end = (state == SHIFT) && out_free && data_last;
`endif
  // Pops are decided from the registered occupancy only.
  assign pop = !fifo_empty && ((state == IDLE) || frame_end);

  // Stage boundary: shift register / FSM feed the registered serial output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      frame_cnt <= 8'd0;
`ifdef TEST_SERIALIZER_PARITY_EN
      par_acc   <= 1'b0;
`endif
    end else begin
      if (ser_valid && ser_ready && ser_last) frame_cnt <= frame_cnt + 8'd1;

      // Nothing to present: drop the output once the sink has it.
      if (out_free && (state == IDLE)) begin
        ser_valid <= 1'b0;
        ser_last  <= 1'b0;
        ser_out   <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            shreg   <= fifo_rd_data;
            bit_cnt <= '0;
            state   <= SHIFT;
`ifdef TEST_SERIALIZER_PARITY_EN
            par_acc <= 1'b0;
`endif
          end
        end

        SHIFT: begin
          if (out_free) begin
            ser_out   <= shreg[FW-1];
            ser_valid <= 1'b1;
            shreg     <= shreg << 1;
            bit_cnt   <= bit_cnt + 1'b1;
`ifdef TEST_SERIALIZER_PARITY_EN
            ser_last  <= 1'b0;
            par_acc   <= par_acc ^ shreg[FW-1];
            if (data_last) state <= PAR;
`else
            ser_last  <= data_last;
            if (data_last) begin
              // Reload in the same edge for zero-gap back-to-back frames.
              if (pop) begin
                shreg   <= fifo_rd_data;
                bit_cnt <= '0;
              end else begin
                state   <= IDLE;
              end
            end
`endif
          end
        end

`ifdef TEST_SERIALIZER_PARITY_EN
        PAR: begin
          if (out_free) begin
            ser_out   <= par_acc;
            ser_valid <= 1'b1;
            ser_last  <= 1'b1;
            par_acc   <= 1'b0;
            bit_cnt   <= '0;
            if (pop) begin
              shreg <= fifo_rd_data;
              state <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_test_serializer.sv
// Self-checking bench for test_serializer: directed table vectors, multi-cycle
// corner sequences and a randomized run against a queue-based bit-stream model.
module tb_test_serializer;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 2;
  localparam int FW         = 2 * DATA_W;
`ifdef TEST_SERIALIZER_PARITY_EN
  localparam int FLEN = FW + 1;
`else
  localparam int FLEN = FW;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              ser_out;
  logic              ser_valid;
  logic              ser_last;
  logic              ser_ready;
  logic [1:0]        fifo_count;
  logic [7:0]        frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  test_serializer #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .ser_last   (ser_last),
    .ser_ready  (ser_ready),
    .fifo_count (fifo_count),
    .frame_cnt  (frame_cnt)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] word;
    logic        par;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected frame: both bytes MSB first, optionally followed by even parity.
  function automatic logic [FLEN-1:0] frame_of(input logic [7:0] a, input logic [7:0] b);
`ifdef TEST_SERIALIZER_PARITY_EN
    return {a, b, ^{a, b}};
`else
    return {a, b};
`endif
  endfunction

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    ser_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!ser_valid && n < budget) begin
      tick();
      n++;
    end
    check("wait_valid", ser_valid, 1'b1);
  endtask

  // Collects one frame. mode 0: ready always 1; mode 1: ready 1,0,1,0...
  task automatic capture(input int mode, input int budget, output logic [FLEN-1:0] word,
                         output int cycles, output int last_err, output int stab_err,
                         output int gaps);
    int   nb = 0;
    logic prev_out = 1'b0;
    logic prev_hold = 1'b0;
    word = '0; cycles = 0; last_err = 0; stab_err = 0; gaps = 0;
    while (!(nb == FLEN && (mode != 1 || cycles % 2 == 0)) && cycles < budget) begin
      ser_ready = (mode == 1) ? (cycles % 2 == 0) : 1'b1;
      if (prev_hold && (ser_out !== prev_out || ser_valid !== 1'b1)) stab_err++;
      if (!ser_valid && ser_ready && nb < FLEN) gaps++;
      if (ser_valid && ser_ready) begin
        word = {word[FLEN-2:0], ser_out};
        nb++;
        if (ser_last !== (nb == FLEN)) last_err++;
      end
      prev_hold = ser_valid && !ser_ready;
      prev_out  = ser_out;
      tick();
      cycles++;
    end
    ser_ready = 1'b0;
    check("capture_bits", nb, FLEN);
  endtask

  vec_t            vecs[7];
  logic [FLEN-1:0] w;
  int              cyc, lerr, serr, gaps;
  logic            exp_bits[$];
  logic            exp_last[$];
  int              model_frames;
  logic            prev_out, prev_hold, lf;
  logic [FLEN-1:0] f;
  int              lasts, guard;

  initial begin
    vecs[0] = '{8'hF3, 8'hE7, 16'hF3E7, 1'b0};
    vecs[1] = '{8'h33, 8'h27, 16'h3327, 1'b0};
    vecs[2] = '{8'h73, 8'h27, 16'h7327, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 16'h0000, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 16'hFFFF, 1'b0};
    vecs[5] = '{8'hA5, 8'h5A, 16'hA55A, 1'b0};
    vecs[6] = '{8'h01, 8'h00, 16'h0100, 1'b1};
    in_a = '0;
    in_b = '0;

    // Reset state
    do_reset();
    check("rst_ser_valid", ser_valid, 0);
    check("rst_ser_last", ser_last, 0);
    check("rst_ser_out", ser_out, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_in_ready", in_ready, 1);

    // Single pair: latency of two edges, then a clean frame
    ser_ready = 1'b1;
    check("single_in_ready", in_ready, 1);
    push(8'hF3, 8'hE7);
    check("lat_k", ser_valid, 0);
    tick();
    check("lat_k1", ser_valid, 0);
    tick();
    check("lat_k2", ser_valid, 1);
    capture(0, 100, w, cyc, lerr, serr, gaps);
    check("single_word", w, frame_of(8'hF3, 8'hE7));
    check("single_last", lerr, 0);
    check("single_frame_cnt", frame_cnt, 1);
    check("single_idle_valid", ser_valid, 0);

    // Backpressure: ready toggles 1,0,...
    do_reset();
    push(8'hF3, 8'hE7);
    wait_valid(10);
    capture(1, 200, w, cyc, lerr, serr, gaps);
    check("bp_word", w, frame_of(8'hF3, 8'hE7));
    check("bp_cycles", cyc, 2 * FLEN);
    check("bp_hold", serr, 0);
    check("bp_last", lerr, 0);
    check("bp_frame_cnt", frame_cnt, 1);

    // Full FIFO, rejected 4th push, back-to-back release
    do_reset();
    in_valid = 1'b1;
    in_a = 8'h33; in_b = 8'h27; tick();
    in_a = 8'h73; in_b = 8'h27; tick();
    check("full_ready_before_3rd", in_ready, 1);
    in_a = 8'hF3; in_b = 8'hE7; tick();
    check("full_count", fifo_count, 2);
    check("full_in_ready", in_ready, 0);
    in_a = 8'h00; in_b = 8'h00; tick();
    in_valid = 1'b0;
    check("full_count_after_reject", fifo_count, 2);
    check("full_valid_held", ser_valid, 1);
    capture(0, 100, w, cyc, lerr, serr, gaps);
    check("full_w1", w, frame_of(8'h33, 8'h27));
    capture(0, 100, w, cyc, lerr, serr, gaps);
    check("full_w2", w, frame_of(8'h73, 8'h27));
    check("full_gap2", gaps, 0);
    capture(0, 100, w, cyc, lerr, serr, gaps);
    check("full_w3", w, frame_of(8'hF3, 8'hE7));
    check("full_gap3", gaps, 0);
    check("full_frame_cnt", frame_cnt, 3);
    check("full_drained_valid", ser_valid, 0);
    check("full_drained_count", fifo_count, 0);

    // Reset in the middle of a frame with another pair buffered
    do_reset();
    push(8'h73, 8'h27);
    push(8'h33, 8'h27);
    wait_valid(10);
    ser_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
    end
    ser_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", ser_valid, 0);
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_frame_cnt", frame_cnt, 0);
    push(8'hF3, 8'hE7);
    wait_valid(10);
    capture(0, 100, w, cyc, lerr, serr, gaps);
    check("mid_rst_new_word", w, frame_of(8'hF3, 8'hE7));
    check("mid_rst_last", lerr, 0);
    tick();
    check("mid_rst_no_leftover", ser_valid, 0);

    // Table-driven single frames
    for (int v = 0; v < 7; v++) begin
      do_reset();
      push(vecs[v].a, vecs[v].b);
      wait_valid(10);
      capture(0, 100, w, cyc, lerr, serr, gaps);
`ifdef TEST_SERIALIZER_PARITY_EN
      check("tbl_word", w[FLEN-1:1], vecs[v].word);
      check("tbl_parity", w[0], vecs[v].par);
`else
      check("tbl_word", w, vecs[v].word);
`endif
      check("tbl_last", lerr, 0);
      check("tbl_frame_cnt", frame_cnt, 1);
    end

    // Randomized traffic against the bit-stream model
    do_reset();
    model_frames = 0;
    prev_hold = 1'b0;
    prev_out = 1'b0;
    for (int c = 0; c < 1200; c++) begin
      in_valid  = (c < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      ser_ready = ($urandom_range(0, 3) != 0);
      if (prev_hold) check("rnd_hold", {ser_valid, ser_out}, {1'b1, prev_out});
      if (ser_valid && ser_ready) begin
        if (exp_bits.size() == 0) begin
          check("rnd_spurious", 1, 0);
        end else begin
          lf = exp_last.pop_front();
          check("rnd_bit", ser_out, exp_bits.pop_front());
          check("rnd_last", ser_last, lf);
          if (lf) model_frames++;
        end
      end
      if (in_valid && in_ready) begin
        f = frame_of(in_a, in_b);
        for (int i = FLEN - 1; i >= 0; i--) begin
          exp_bits.push_back(f[i]);
          exp_last.push_back(i == 0);
        end
      end
      prev_hold = ser_valid && !ser_ready;
      prev_out  = ser_out;
      tick();
      check("rnd_frame_cnt", frame_cnt, model_frames % 256);
    end
    ser_ready = 1'b1;
    guard = 0;
    while (exp_bits.size() > 0 && guard < 300) begin
      if (ser_valid) begin
        lf = exp_last.pop_front();
        check("drain_bit", ser_out, exp_bits.pop_front());
        check("drain_last", ser_last, lf);
        if (lf) model_frames++;
      end
      tick();
      guard++;
    end
    check("rnd_drained", exp_bits.size(), 0);
    check("rnd_final_frame_cnt", frame_cnt, model_frames % 256);
    tick();
    check("rnd_idle", ser_valid, 0);

    // frame_cnt wrap over 256 frames
    do_reset();
    in_a = 8'h33;
    in_b = 8'h27;
    in_valid = 1'b1;
    ser_ready = 1'b1;
    lasts = 0;
    guard = 0;
    while (lasts < 256 && guard < 256 * FLEN + 200) begin
      if (ser_valid && ser_last) lasts++;
      tick();
      guard++;
      if (lasts == 255 && ser_valid && ser_last) check("wrap_255", frame_cnt, 255);
    end
    in_valid = 1'b0;
    check("wrap_frames_seen", lasts, 256);
    check("wrap_zero", frame_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
